// File: rtl/y86_imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// y86_imem_loader_pkg
//  Shared definitions for the boot-time instruction memory loader:
//   - default memory geometry and frame start marker
//   - loader FSM state encoding
//   - frame_fits(): range check of a frame against the memory size
// -----------------------------------------------------------------------------
package y86_imem_loader_pkg;

   localparam int         MEM_BYTES_DEF = 1024;
   localparam int         ADDR_W_DEF    = 10;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_L0,
      ST_L1,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_e;

   // base+len is formed in 17 bits so a large base cannot wrap past zero
   // and sneak under the limit.
   function automatic logic frame_fits(input logic [15:0] base,
                                       input logic [15:0] len,
                                       input logic [16:0] mem_bytes);
      logic [16:0] end_addr;
      end_addr = {1'b0, base} + {1'b0, len};
      return (end_addr <= mem_bytes);
   endfunction

endpackage

// File: rtl/y86_imem_loader_if.sv
// -----------------------------------------------------------------------------
// y86_imem_loader_if
//  Byte-stream input handshake plus instruction-memory write port of the
//  loader, bundled together.
//   in_valid  : stream byte valid            (master -> loader)
//   in_data   : stream byte                  (master -> loader)
//   in_ready  : loader accepts byte          (loader -> master)
//   mem_we    : one-byte write strobe        (loader -> memory)
//   mem_addr  : write address, ADDR_W bits   (loader -> memory)
//   mem_wdata : write data                   (loader -> memory)
//  modport slave  : the loader side
//  modport master : the host/stream side (also observes the write port)
// -----------------------------------------------------------------------------
interface y86_imem_loader_if
   import y86_imem_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/y86_imem_loader.sv
// -----------------------------------------------------------------------------
// y86_imem_loader
//  Boot-time program loader in front of the y86 fetch instruction memory.
//  Parses the frame  SYNC, BASE[7:0], BASE[15:8], LEN[7:0], LEN[15:8],
//  LEN payload bytes, CSUM (XOR of payload)  and writes the payload to
//  memory starting at BASE. The CPU is held in reset until a frame has
//  loaded with a good checksum.
//  Ports:
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   bus        : slave side of y86_imem_loader_if (stream in, memory write out)
//   cpu_rst_n  : CPU reset, high only after a good load
//   load_done  : frame loaded, checksum good
//   load_err   : sticky frame error (range or checksum)
// -----------------------------------------------------------------------------
module y86_imem_loader
   import y86_imem_loader_pkg::*;
#(
   parameter int         MEM_BYTES = MEM_BYTES_DEF,
   parameter int         ADDR_W    = ADDR_W_DEF,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   y86_imem_loader_if.slave bus,
   output logic             cpu_rst_n,
   output logic             load_done,
   output logic             load_err
);

   localparam logic [16:0] MEM_BYTES_17 = 17'(MEM_BYTES);

   loader_state_e     state_q;
   logic [15:0]       base_q;
   logic [15:0]       len_q;
   logic [15:0]       idx_q;
   logic [7:0]        xor_q;
   logic              in_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;
   logic              run_q;        // drives both cpu_rst_n and load_done
   logic              load_err_q;

   logic              accept;
   logic              is_sync;
   logic              last_data;
   logic [15:0]       len_d;
   logic [ADDR_W-1:0] wr_addr_d;

   always_comb begin
      accept    = bus.in_valid & in_ready_q;
      is_sync   = (bus.in_data == SYNC_BYTE);
      len_d     = {bus.in_data, len_q[7:0]};
      last_data = (idx_q == (len_q - 16'd1));
      // Range check in L1 guarantees base+idx < MEM_BYTES, so the
      // truncated sum is the true address.
      wr_addr_d = base_q[ADDR_W-1:0] + idx_q[ADDR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         xor_q       <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         run_q       <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         mem_we_q   <= 1'b0;
         in_ready_q <= (state_q != ST_ERR);
         // Rises one cycle after the state reaches DONE; the SYNC branch
         // below pulls it low immediately when a new frame starts.
         run_q      <= (state_q == ST_DONE);

         if (accept) begin
            case (state_q)
               ST_IDLE: begin
                  if (is_sync) begin
                     state_q <= ST_B0;
                     xor_q   <= '0;
                  end
               end
               ST_B0: begin
                  base_q[7:0] <= bus.in_data;
                  state_q     <= ST_B1;
               end
               ST_B1: begin
                  base_q[15:8] <= bus.in_data;
                  state_q      <= ST_L0;
               end
               ST_L0: begin
                  len_q[7:0] <= bus.in_data;
                  state_q    <= ST_L1;
               end
               ST_L1: begin
                  len_q <= len_d;
                  idx_q <= '0;
                  if (!frame_fits(base_q, len_d, MEM_BYTES_17)) begin
                     state_q    <= ST_ERR;
                     load_err_q <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else if (len_d == 16'd0) begin
                     state_q <= ST_CSUM;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= wr_addr_d;
                  mem_wdata_q <= bus.in_data;
                  // Folded in here so it is already current when CSUM
                  // arrives on the very next cycle.
                  xor_q       <= xor_q ^ bus.in_data;
                  idx_q       <= idx_q + 16'd1;
                  if (last_data) begin
                     state_q <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  if (bus.in_data == xor_q) begin
                     state_q <= ST_DONE;
                  end else begin
                     state_q    <= ST_ERR;
                     load_err_q <= 1'b1;
                     in_ready_q <= 1'b0;
                  end
               end
               ST_DONE: begin
                  if (is_sync) begin
                     state_q <= ST_B0;
                     xor_q   <= '0;
                     run_q   <= 1'b0;
                  end
               end
               default: begin
                  // ST_ERR never accepts (in_ready is low); held until reset.
               end
            endcase
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_rst_n     = run_q;
   assign load_done     = run_q;
   assign load_err      = load_err_q;

endmodule

// File: tb/tb_y86_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_y86_imem_loader
//  Directed frame sequence with randomized payloads and randomized in_valid
//  gaps. Expected writes and frame outcome come from the frame rules:
//  payload lands at base+i when base+len <= memory size, and the load
//  succeeds only when the trailing byte equals the XOR of the payload.
// -----------------------------------------------------------------------------
module tb_y86_imem_loader;
   import y86_imem_loader_pkg::*;

   localparam int MEM_BYTES = 1024;
   localparam int ADDR_W    = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cpu_rst_n;
   logic load_done;
   logic load_err;

   always #5 clk = ~clk;

   y86_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   y86_imem_loader #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .load_done (load_done),
      .load_err  (load_err)
   );

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0]  pay_q[$];
   logic [17:0] obs_q[$];   // {addr, data} of every observed write pulse

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int guard;
      if (gaps) begin
         int idle;
         idle = $urandom_range(0, 2);
         repeat (idle) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("accept_in_time", 32'(guard < 20), 32'd1);
      if (guard < 20) @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic offer_bytes(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         @(negedge clk);
         check({tag, "_no_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic fill_random(input int n);
      pay_q.delete();
      repeat (n) pay_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // csum_force < 0 sends the correct checksum, otherwise sends csum_force.
   task automatic run_frame(input string tag, input int base, input int len,
                            input int csum_force, input bit gaps, input bit garbage);
      logic [7:0]  x;
      logic [7:0]  csum;
      logic [17:0] e;
      bit          fits;
      bit          exp_done;
      int          n_exp;
      x = 8'h00;
      foreach (pay_q[i]) x ^= pay_q[i];
      csum     = (csum_force < 0) ? x : 8'(csum_force);
      fits     = (base + len) <= MEM_BYTES;
      exp_done = fits && (csum == x);
      n_exp    = fits ? len : 0;
      obs_q.delete();

      if (garbage) begin
         send_byte(8'h11, gaps);
         send_byte(8'h22, gaps);
      end
      send_byte(8'hA5, gaps);
      check({tag, "_cpu_rst_after_sync"}, 32'(cpu_rst_n), 32'd0);
      check({tag, "_done_after_sync"}, 32'(load_done), 32'd0);
      send_byte(8'(base), gaps);
      send_byte(8'(base >> 8), gaps);
      send_byte(8'(len), gaps);
      send_byte(8'(len >> 8), gaps);
      if (fits) begin
         foreach (pay_q[i]) begin
            send_byte(pay_q[i], gaps);
            check({tag, "_cpu_held"}, 32'(cpu_rst_n), 32'd0);
         end
         send_byte(csum, gaps);
      end else begin
         offer_bytes(tag, 3);
      end
      repeat (3) @(negedge clk);

      check({tag, "_wr_count"}, 32'(obs_q.size()), 32'(n_exp));
      for (int i = 0; i < n_exp && i < obs_q.size(); i++) begin
         e = {ADDR_W'(base + i), pay_q[i]};
         check({tag, "_wr"}, 32'(obs_q[i]), 32'(e));
      end
      check({tag, "_load_done"}, 32'(load_done), 32'(exp_done));
      check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
      check({tag, "_load_err"}, 32'(load_err), 32'(!exp_done));
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_done));
      $display("frame %s base=0x%0h len=%0d csum=0x%0h writes=%0d done=%0b err=%0b",
               tag, base, len, csum, obs_q.size(), load_done, load_err);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_err", 32'(load_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.in_ready), 32'd1);

      // Basic three-byte frame at 0
      pay_q = '{8'h30, 8'hF4, 8'h64};
      run_frame("basic", 0, 3, -1, 1'b0, 1'b0);

      // Reload from DONE at 0xA0; CPU held low throughout
      fill_random(8);
      run_frame("reload_a0", 'hA0, 8, -1, 1'b1, 1'b0);

      // Program at 0: irmovq $5,%rax ; halt
      pay_q = '{8'h30, 8'hF0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame("program", 0, 11, -1, 1'b0, 1'b0);

      // Empty frame behind garbage bytes
      do_reset();
      pay_q.delete();
      run_frame("empty", 'h10, 0, 8'h00, 1'b0, 1'b1);

      // Basic frame again with random in_valid gaps
      pay_q = '{8'h30, 8'hF4, 8'h64};
      run_frame("gappy", 0, 3, -1, 1'b1, 1'b0);

      // Reset in the middle of DATA: partial writes remain, CPU held
      fill_random(6);
      obs_q.delete();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h40, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h06, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(pay_q[i], 1'b1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("midrst_load_done", 32'(load_done), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("midrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("midrst_partial_cnt", 32'(obs_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
         check("midrst_partial_wr", 32'(obs_q[i]), 32'({ADDR_W'('h40 + i), pay_q[i]}));
      end
      $display("frame midrst base=0x40 len=6 aborted writes=%0d", obs_q.size());
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      fill_random(16);
      run_frame("fresh", 'h100, 16, -1, 1'b1, 1'b0);

      // Frame ending exactly at the top of memory
      fill_random(3);
      run_frame("top_fit", 'h3FD, 3, -1, 1'b0, 1'b0);

      // Wrong checksum: sticky error, no further accepts or writes
      pay_q = '{8'h30, 8'hF4, 8'h64};
      run_frame("bad_csum", 0, 3, 8'hE1, 1'b0, 1'b0);
      obs_q.delete();
      offer_bytes("err_sticky", 5);
      check("err_sticky_no_wr", 32'(obs_q.size()), 32'd0);
      check("err_sticky_err", 32'(load_err), 32'd1);
      check("err_sticky_cpu", 32'(cpu_rst_n), 32'd0);

      // Out-of-range frame: error after the length, no writes
      do_reset();
      fill_random(3);
      run_frame("range", 'h3FE, 3, -1, 1'b0, 1'b0);

      // Maximal base and length must not wrap into range
      do_reset();
      pay_q.delete();
      run_frame("wrap", 'hFFFF, 'hFFFF, -1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
